div_seq_unit: RTL and testbench
===============================

// Module: div_seq_unit
// PURPOSE
//  Execute-stage sequential divider with built-in pipeline handshake for the MIPS core.
//  Decodes DIV/DIVU from alucontrolE (`DIV_CONTROL / `DIVU_CONTROL, defines.vh), captures operands,
//  iterates BPC quotient bits per cycle, requests a pipeline stall until done, and supports flush.
//  Result {HI=remainder, LO=quotient} goes to the HI/LO write path in M.
// PARAMETERS
//  WIDTH  32  operand width; must be a multiple of BPC
//  BPC    1   quotient bits per cycle, 1 or 2; iterations N = WIDTH/BPC
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-low
//  alucontrolE  in   5        E-stage ALU control; DIV/DIVU selects this unit
//  srcaE        in   WIDTH    dividend (rs)
//  srcbE        in   WIDTH    divisor (rt)
//  flushE       in   1        annul the E-stage instruction; abort any operation
//  holdE        in   1        external stall holding E (another unit stalls the pipe)
//  stall_req    out  1        stall request to the hazard unit
//  div_ready    out  1        result valid this cycle
//  div_by_zero  out  1        completed op had divisor 0 (valid with div_ready)
//  hilo_out     out  2*WIDTH  {remainder, quotient}
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, counter=0; stall_req=0, div_ready=0, div_by_zero=0, hilo_out=0.
//  - hit = (alucontrolE==`DIV_CONTROL || alucontrolE==`DIVU_CONTROL); sgn = (alucontrolE==`DIV_CONTROL).
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: hit & !flushE -> latch |a|,|b| (abs only when sgn), latch sgn, neg_q = sgn&(a[W-1]^b[W-1]),
//          neg_r = sgn&a[W-1]; counter=0. Divisor 0 -> skip BUSY, go to DONE with div_by_zero=1.
//    BUSY: one restoring-division step per BPC bit per cycle; after N BUSY cycles -> DONE.
//          On the DONE transition, hilo_out is registered: q = neg_q ? -q : q, r = neg_r ? -r : r.
//    DONE: div_ready=1. If holdE=1 stay in DONE (ready stays 1, no restart); else -> IDLE.
//  - Latency (WIDTH=32, BPC=1): hit in cycle t -> div_ready in cycle t+33; BPC=2 -> t+17; zero divisor -> t+1.
//  - stall_req = hit & !flushE & (state!=DONE), combinational. High in the hit cycle in IDLE and in all
//    BUSY cycles; low in DONE so E advances with the result.
//  - flushE=1 in any state: stall_req=0; next state IDLE; hilo_out unchanged; div_ready=0 next cycle.
//    flushE with hit in IDLE: no start.
//  - Divide by zero: quotient = all ones; remainder = dividend (raw srcaE). Sign fix is not applied.
//  - Signed overflow MIN/-1: quotient=MIN, remainder=0 (falls out of the abs/negate path, no special case).
//  - Arithmetic: unsigned WIDTH-bit magnitudes; partial remainder WIDTH+1 bits; |MIN| treated as 2^(W-1).
//  - Operands are latched; srcaE/srcbE changes during BUSY have no effect.
//  - hilo_out holds its value until the next DONE transition.
//  - Back-to-back divides: after DONE->IDLE, a new hit in that IDLE cycle starts immediately.
//  - Non-div alucontrolE during BUSY: no effect on the running op; it completes and goes to DONE.
// TESTING
//  1 DIVU 100/7, W=32 BPC=1 -> stall_req 33 cycles (t..t+32), div_ready at t+33, hilo_out={2,14}.
//  2 DIV -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); DIV 7/-2 -> q=-3, r=1.
//  3 DIVU 5/0 -> div_ready at t+1, div_by_zero=1, hilo_out={5,0xFFFFFFFF}; DIV 0x80000000/-1 -> q=0x80000000, r=0.
//  4 flushE pulse at BUSY cycle 10 -> stall_req=0 in that cycle, IDLE next cycle, no div_ready,
//    hilo_out unchanged; then DIVU 9/3 -> {0,3}.
//  5 holdE=1 for 3 cycles at DONE -> div_ready held 4 cycles, no restart, stall_req=0; then IDLE.
//  6 BPC=2, random 1000 signed/unsigned pairs vs reference model, latency t+17; assert rst low mid-BUSY
//    -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_seq_unit.sv
// Execute-stage sequential restoring divider for DIV/DIVU with a stall/flush/hold handshake.
// The result {remainder, quotient} is registered on entry to DONE and held until the next completion.
//
//   state | meaning
//   IDLE  | waiting for a DIV/DIVU in E; captures operand magnitudes and sign flags on a hit
//   BUSY  | BPC restoring-division steps per cycle for WIDTH/BPC cycles
//   DONE  | result valid; stays while holdE is high, otherwise returns to IDLE
module div_seq_unit #(
    parameter int         WIDTH        = 32,
    parameter int         BPC          = 1,
    parameter logic [4:0] DIV_CONTROL  = 5'b11010,
    parameter logic [4:0] DIVU_CONTROL = 5'b11011
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           alucontrolE,
    input  logic [WIDTH-1:0]     srcaE,
    input  logic [WIDTH-1:0]     srcbE,
    input  logic                 flushE,
    input  logic                 holdE,
    output logic                 stall_req,
    output logic                 div_ready,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   hilo_out
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] hilo_q, hilo_d;

    logic               hit, sgn;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     rem_w;
    logic [WIDTH-1:0]   quo_w, q_fin, r_fin;

    assign hit   = (alucontrolE == DIV_CONTROL) || (alucontrolE == DIVU_CONTROL);
    assign sgn   = (alucontrolE == DIV_CONTROL);
    // Negating MIN yields MIN, which read as unsigned is exactly 2^(WIDTH-1).
    assign a_abs = (sgn && srcaE[WIDTH-1]) ? (WIDTH'(0) - srcaE) : srcaE;
    assign b_abs = (sgn && srcbE[WIDTH-1]) ? (WIDTH'(0) - srcbE) : srcbE;

    // quo_q starts as the dividend and shifts left; quotient bits fill in from the bottom.
    always_comb begin
        rem_w = rem_q;
        quo_w = quo_q;
        for (int i = 0; i < BPC; i++) begin
            rem_w = {rem_w[WIDTH-1:0], quo_w[WIDTH-1]};
            quo_w = {quo_w[WIDTH-2:0], 1'b0};
            if (rem_w >= {1'b0, dsr_q}) begin
                rem_w    = rem_w - {1'b0, dsr_q};
                quo_w[0] = 1'b1;
            end
        end
    end

    assign q_fin = negq_q ? (WIDTH'(0) - quo_w) : quo_w;
    assign r_fin = negr_q ? (WIDTH'(0) - rem_w[WIDTH-1:0]) : rem_w[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dbz_d   = dbz_q;
        hilo_d  = hilo_q;
        if (flushE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        quo_d  = a_abs;
                        dsr_d  = b_abs;
                        rem_d  = '0;
                        cnt_d  = '0;
                        negq_d = sgn & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                        negr_d = sgn & srcaE[WIDTH-1];
                        if (srcbE == '0) begin
                            state_d = S_DONE;
                            dbz_d   = 1'b1;
                            hilo_d  = {srcaE, {WIDTH{1'b1}}};
                        end else begin
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    quo_d = quo_w;
                    rem_d = rem_w;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b0;
                        hilo_d  = {r_fin, q_fin};
                    end
                end
                S_DONE: begin
                    if (!holdE) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hilo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dbz_q   <= dbz_d;
            hilo_q  <= hilo_d;
        end
    end

    assign stall_req   = hit & ~flushE & (state_q != S_DONE);
    assign div_ready   = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign hilo_out    = hilo_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed and randomized checks of div_seq_unit: one instance with BPC=1, one with BPC=2.
module tb_div_seq_unit;

    localparam logic [4:0] NOP  = 5'b00000;
    localparam logic [4:0] DIV  = 5'b11010;
    localparam logic [4:0] DIVU = 5'b11011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ctrl;
    logic [31:0] srca, srcb;
    logic        flush, hold;

    logic        stall1, rdy1, dbz1, stall2, rdy2, dbz2;
    logic [63:0] hilo1, hilo2;

    logic        sel;
    logic        stall, rdy, dbz;
    logic [63:0] hilo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_seq_unit #(.WIDTH(32), .BPC(1), .DIV_CONTROL(DIV), .DIVU_CONTROL(DIVU)) dut1 (
        .clk(clk), .rst(rst_n), .alucontrolE(ctrl), .srcaE(srca), .srcbE(srcb),
        .flushE(flush), .holdE(hold), .stall_req(stall1), .div_ready(rdy1),
        .div_by_zero(dbz1), .hilo_out(hilo1));

    div_seq_unit #(.WIDTH(32), .BPC(2), .DIV_CONTROL(DIV), .DIVU_CONTROL(DIVU)) dut2 (
        .clk(clk), .rst(rst_n), .alucontrolE(ctrl), .srcaE(srca), .srcbE(srcb),
        .flushE(flush), .holdE(hold), .stall_req(stall2), .div_ready(rdy2),
        .div_by_zero(dbz2), .hilo_out(hilo2));

    assign stall = sel ? stall2 : stall1;
    assign rdy   = sel ? rdy2   : rdy1;
    assign dbz   = sel ? dbz2   : dbz1;
    assign hilo  = sel ? hilo2  : hilo1;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Presents one op in the current cycle and holds it while the selected unit is busy.
    task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int lat, output int stl_cnt,
                          output logic [63:0] h, output logic z, output logic stl_at_rdy);
        ctrl = c; srca = a; srcb = b;
        lat = -1; stl_cnt = 0; h = '0; z = 1'b0; stl_at_rdy = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (disturb && k == 2) begin
                srca = $urandom; srcb = '0; ctrl = NOP;
            end
            @(negedge clk);
            if (rdy) begin
                lat = k; h = hilo; z = dbz; stl_at_rdy = stall;
                break;
            end
            if (stall) stl_cnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ctrl = NOP;
    endtask

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; ctrl = NOP; srca = '0; srcb = '0; flush = 1'b0; hold = 1'b0; sel = 1'b0;
        #12;
        total++;
        if ({stall1, rdy1, dbz1, hilo1} !== 67'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {stall1, rdy1, dbz1, hilo1});
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int lat, sc; logic [63:0] h; logic z, sr;
        sel = 1'b0;
        run_op(DIVU, 32'd100, 32'd7, 1'b0, lat, sc, h, z, sr);
        total += 4;
        if (lat !== 33) begin bad++; $display("FAIL divu_latency got=%0d want=33", lat); end
        if (sc !== 33) begin bad++; $display("FAIL divu_stall_cycles got=%0d want=33", sc); end
        if (sr !== 1'b0) begin bad++; $display("FAIL divu_stall_at_done got=%b want=0", sr); end
        if (h !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7 got=%h want=%h", h, {32'd2, 32'd14}); end
    endtask

    task automatic test_signed();
        int lat, sc; logic [63:0] h; logic z, sr;
        sel = 1'b0;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, sc, h, z, sr);
        total += 2;
        if (h !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_m7_2 got=%h want=ffffffff_fffffffd", h); end
        if (lat !== 33) begin bad++; $display("FAIL div_m7_2_latency got=%0d want=33", lat); end
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, sc, h, z, sr);
        total++;
        if (h !== 64'h0000_0001_FFFF_FFFD) begin bad++; $display("FAIL div_7_m2 got=%h want=00000001_fffffffd", h); end
    endtask

    task automatic test_corner();
        int lat, sc; logic [63:0] h; logic z, sr;
        sel = 1'b0;
        run_op(DIVU, 32'd5, 32'd0, 1'b0, lat, sc, h, z, sr);
        total += 4;
        if (lat !== 1) begin bad++; $display("FAIL div0_latency got=%0d want=1", lat); end
        if (z !== 1'b1) begin bad++; $display("FAIL div0_flag got=%b want=1", z); end
        if (h !== 64'h0000_0005_FFFF_FFFF) begin bad++; $display("FAIL div0_result got=%h want=00000005_ffffffff", h); end
        if (sc !== 1) begin bad++; $display("FAIL div0_stall_cycles got=%0d want=1", sc); end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, sc, h, z, sr);
        total += 2;
        if (h !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_min_m1 got=%h want=00000000_80000000", h); end
        if (z !== 1'b0) begin bad++; $display("FAIL div_min_m1_flag got=%b want=0", z); end
    endtask

    task automatic test_flush();
        int lat, sc, rc; logic [63:0] h; logic z, sr;
        sel = 1'b0;
        ctrl = DIVU; srca = 32'd1000; srcb = 32'd3;
        idle(10);
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (stall1 !== 1'b0) begin bad++; $display("FAIL flush_busy_stall got=%b want=0", stall1); end
        @(posedge clk); #1;
        flush = 1'b0; ctrl = NOP;
        rc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy1) rc++;
        end
        total += 2;
        if (rc !== 0) begin bad++; $display("FAIL flush_busy_ready got=%0d want=0", rc); end
        if (hilo1 !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL flush_hilo_kept got=%h want=00000000_80000000", hilo1); end
        @(posedge clk); #1;
        ctrl = DIVU; srca = 32'd9; srcb = 32'd3; flush = 1'b1;
        @(negedge clk);
        total++;
        if (stall1 !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b want=0", stall1); end
        @(posedge clk); #1;
        flush = 1'b0; ctrl = NOP;
        rc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy1) rc++;
        end
        total++;
        if (rc !== 0) begin bad++; $display("FAIL flush_idle_ready got=%0d want=0", rc); end
        @(posedge clk); #1;
        run_op(DIVU, 32'd9, 32'd3, 1'b0, lat, sc, h, z, sr);
        total += 2;
        if (h !== 64'h0000_0000_0000_0003) begin bad++; $display("FAIL divu_9_3 got=%h want=00000000_00000003", h); end
        if (lat !== 33) begin bad++; $display("FAIL divu_9_3_latency got=%0d want=33", lat); end
    endtask

    task automatic test_hold();
        int rc, sb_cnt; logic [63:0] h; logic r36, r37;
        sel = 1'b0;
        ctrl = DIVU; srca = 32'd20; srcb = 32'd6;
        rc = 0; sb_cnt = 0; h = '0; r36 = 1'b0; r37 = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            hold = (k >= 33 && k <= 35);
            if (k == 37) ctrl = NOP;
            @(negedge clk);
            if (rdy1) rc++;
            if (k >= 33 && stall1) sb_cnt++;
            if (k == 33) h = hilo1;
            if (k == 36) r36 = rdy1;
            if (k == 37) r37 = rdy1;
            @(posedge clk); #1;
        end
        hold = 1'b0;
        total += 5;
        if (rc !== 4) begin bad++; $display("FAIL hold_ready_cycles got=%0d want=4", rc); end
        if (sb_cnt !== 0) begin bad++; $display("FAIL hold_stall got=%0d want=0", sb_cnt); end
        if (h !== {32'd2, 32'd3}) begin bad++; $display("FAIL hold_result got=%h want=%h", h, {32'd2, 32'd3}); end
        if (r36 !== 1'b1) begin bad++; $display("FAIL hold_last_ready got=%b want=1", r36); end
        if (r37 !== 1'b0) begin bad++; $display("FAIL hold_release got=%b want=0", r37); end
    endtask

    task automatic test_back_to_back();
        int lat, sc; logic [63:0] h; logic z, sr;
        sel = 1'b0;
        run_op(DIVU, 32'd100, 32'd7, 1'b0, lat, sc, h, z, sr);
        run_op(DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0, lat, sc, h, z, sr);
        total += 2;
        if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
        if (h !== 64'h0000_000F_0FFF_FFFF) begin bad++; $display("FAIL b2b_result got=%h want=0000000f_0fffffff", h); end
    endtask

    task automatic test_operand_latch();
        int lat, sc; logic [63:0] h; logic z, sr;
        sel = 1'b0;
        run_op(DIVU, 32'd1000, 32'd3, 1'b1, lat, sc, h, z, sr);
        total += 3;
        if (h !== {32'd1, 32'd333}) begin bad++; $display("FAIL latch_result got=%h want=%h", h, {32'd1, 32'd333}); end
        if (lat !== 33) begin bad++; $display("FAIL latch_latency got=%0d want=33", lat); end
        if (sc !== 2) begin bad++; $display("FAIL latch_stall_cycles got=%0d want=2", sc); end
    endtask

    task automatic test_bpc2_random();
        int lat, sc, nbad; logic [63:0] h, want; logic z, sr, s;
        logic [31:0] a, b;
        logic [4:0] c;
        sel = 1'b1;
        idle(40);
        nbad = 0;
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            c = s ? DIV : DIVU;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd1;
            if (i == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; c = DIV; s = 1'b1; end
            want = ref_div(s, a, b);
            run_op(c, a, b, 1'b0, lat, sc, h, z, sr);
            total += 2;
            if (h !== want) begin
                bad++;
                if (nbad < 10) $display("FAIL bpc2_result op=%0d a=%h b=%h got=%h want=%h", c, a, b, h, want);
                nbad++;
            end
            if (lat !== 17) begin
                bad++;
                if (nbad < 10) $display("FAIL bpc2_latency got=%0d want=17", lat);
                nbad++;
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat, sc, rc; logic [63:0] h; logic z, sr;
        sel = 1'b1;
        run_op(DIVU, 32'd100, 32'd7, 1'b0, lat, sc, h, z, sr);
        total++;
        if (h !== {32'd2, 32'd14}) begin bad++; $display("FAIL bpc2_pre_reset got=%h want=%h", h, {32'd2, 32'd14}); end
        ctrl = DIVU; srca = 32'd1000; srcb = 32'd3;
        idle(5);
        ctrl = NOP; rst_n = 1'b0;
        #1;
        total++;
        if ({stall2, rdy2, dbz2, hilo2} !== 67'd0) begin
            bad++; $display("FAIL reset_mid_busy got=%h want=0", {stall2, rdy2, dbz2, hilo2});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rc = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rdy2) rc++;
        end
        total++;
        if (rc !== 0) begin bad++; $display("FAIL reset_abort_ready got=%0d want=0", rc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_corner();
        test_flush();
        test_hold();
        test_back_to_back();
        test_operand_latch();
        test_bpc2_random();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
